// File: rtl/rcvr_param.sv
// Serial frame receiver: hunts for a programmable header, then shifts in
// a payload MSB first, with optional parity check and polled ready/overrun.
module rcvr_param #(
    parameter int                    HEAD_WIDTH   = 8,
    parameter logic [HEAD_WIDTH-1:0] HEAD_PATTERN = 8'hA5,
    parameter int                    BODY_WIDTH   = 8,
    parameter int                    PARITY_EN    = 0,
    parameter int                    PARITY_ODD   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  data_in,
    input  logic                  reading,
    output logic                  ready,
    output logic                  overrun,
    output logic                  parity_err,
    output logic [BODY_WIDTH-1:0] data_out
);

    localparam int CW = $clog2(BODY_WIDTH + 1);
    localparam int FW = $clog2(HEAD_WIDTH + 1);
    localparam logic [CW-1:0] LAST     = CW'(BODY_WIDTH - 1);
    localparam logic [FW-1:0] FULL     = FW'(HEAD_WIDTH);
    localparam logic [FW-1:0] FILL_MIN = FW'(HEAD_WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        BODY = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t                r_state;
    logic [HEAD_WIDTH-1:0] r_win;
    logic [FW-1:0]         r_fill;
    logic [CW-1:0]         r_cnt;
    logic [BODY_WIDTH-1:0] r_body;
    logic                  r_ready;
    logic                  r_overrun;
    logic                  r_perr;
    logic [BODY_WIDTH-1:0] r_data;

    logic [HEAD_WIDTH-1:0] w_win_next;
    logic [BODY_WIDTH-1:0] w_body_next;
    logic                  w_match;
    logic                  w_par_ok;
    logic                  w_done;
    logic                  w_drop;
    logic [BODY_WIDTH-1:0] w_done_data;

    assign w_win_next = {r_win[HEAD_WIDTH-2:0], data_in};

    generate
        if (BODY_WIDTH == 1) begin : g_body1
            assign w_body_next = data_in;
        end else begin : g_bodyn
            assign w_body_next = {r_body[BODY_WIDTH-2:0], data_in};
        end
    endgenerate

    // Sliding compare: the window counts only once it holds a full header.
    assign w_match = (r_fill >= FILL_MIN) && (w_win_next == HEAD_PATTERN);

    assign w_par_ok = ((^{r_body, data_in}) == (PARITY_ODD != 0));

    assign w_done = ((r_state == BODY) && (r_cnt == LAST) && (PARITY_EN == 0))
                 || ((r_state == PAR) && (PARITY_EN != 0) && w_par_ok);

    assign w_drop = (r_state == PAR) && (PARITY_EN != 0) && !w_par_ok;

    assign w_done_data = (r_state == PAR) ? r_body : w_body_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= HUNT;
            r_win     <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_body    <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_perr    <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                HUNT: begin
                    r_win <= w_win_next;
                    if (r_fill != FULL) begin
                        r_fill <= r_fill + 1'b1;
                    end
                    if (w_match) begin
                        r_state <= BODY;
                        r_cnt   <= '0;
                    end
                end
                BODY: begin
                    r_body <= w_body_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= (PARITY_EN != 0) ? PAR : HUNT;
                        r_win   <= '0;
                        r_fill  <= '0;
                    end
                end
                PAR: begin
                    r_state <= HUNT;
                    r_win   <= '0;
                    r_fill  <= '0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= HUNT;
                    r_win   <= '0;
                    r_fill  <= '0;
                    r_cnt   <= '0;
                end
            endcase

            if (w_done) begin
                r_ready <= 1'b1;
                r_data  <= w_done_data;
            end else if (reading) begin
                r_ready <= 1'b0;
            end

            if (reading) begin
                r_overrun <= 1'b0;
            end else if (w_done && r_ready) begin
                r_overrun <= 1'b1;
            end

            if (reading) begin
                r_perr <= 1'b0;
            end else if (w_drop) begin
                r_perr <= 1'b1;
            end
        end
    end

    assign ready      = r_ready;
    assign overrun    = r_overrun;
    assign parity_err = r_perr;
    assign data_out   = r_data;

endmodule

// File: tb/tb_rcvr_param.sv
// Directed bench for rcvr_param: default 8-bit receiver plus a
// 4-bit-header, 12-bit-body, odd-parity instance, with payload scoreboards.
module tb_rcvr_param;

    logic        clk;
    logic        rst_n;
    logic        d_a, rd_a, d_b, rd_b;
    logic        ready_a, ovr_a, perr_a;
    logic [7:0]  data_a;
    logic        ready_b, ovr_b, perr_b;
    logic [11:0] data_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    rcvr_param dut_a (
        .clock      (clk),
        .reset_n    (rst_n),
        .data_in    (d_a),
        .reading    (rd_a),
        .ready      (ready_a),
        .overrun    (ovr_a),
        .parity_err (perr_a),
        .data_out   (data_a)
    );

    rcvr_param #(
        .HEAD_WIDTH   (4),
        .HEAD_PATTERN (4'hB),
        .BODY_WIDTH   (12),
        .PARITY_EN    (1),
        .PARITY_ODD   (1)
    ) dut_b (
        .clock      (clk),
        .reset_n    (rst_n),
        .data_in    (d_b),
        .reading    (rd_b),
        .ready      (ready_b),
        .overrun    (ovr_b),
        .parity_err (perr_b),
        .data_out   (data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int sel, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (sel == 0) d_a = v[i];
            else          d_b = v[i];
            tick();
        end
        if (sel == 0) d_a = 1'b0;
        else          d_b = 1'b0;
    endtask

    task automatic pop_check(input int sel, input string tag);
        logic [31:0] e;
        if (sel == 0) begin
            if (q_a.size() == 0) begin
                check({tag, "_qempty"}, 32'd0, 32'd1);
            end else begin
                e = q_a.pop_front();
                check(tag, {24'd0, data_a}, e);
            end
        end else begin
            if (q_b.size() == 0) begin
                check({tag, "_qempty"}, 32'd0, 32'd1);
            end else begin
                e = q_b.pop_front();
                check(tag, {20'd0, data_b}, e);
            end
        end
    endtask

    task automatic read_pulse(input int sel);
        if (sel == 0) rd_a = 1'b1;
        else          rd_b = 1'b1;
        tick();
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    initial begin
        logic [7:0] rnd;
        rst_n = 1'b0;
        d_a = 1'b0; rd_a = 1'b0;
        d_b = 1'b0; rd_b = 1'b0;
        tick();
        tick();
        check("rst_ready_a", {31'd0, ready_a}, 32'd0);
        check("rst_ovr_a",   {31'd0, ovr_a},   32'd0);
        check("rst_perr_a",  {31'd0, perr_a},  32'd0);
        check("rst_data_a",  {24'd0, data_a},  32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd0);
        check("rst_data_b",  {20'd0, data_b},  32'd0);
        rst_n = 1'b1;

        // basic frame, ready appears only after the last bit
        send(0, 32'hA5, 8);
        q_a.push_back(32'h3C);
        send(0, 32'h1E, 7);
        check("t1_ready_early", {31'd0, ready_a}, 32'd0);
        send(0, 32'h0, 1);
        check("t1_ready", {31'd0, ready_a}, 32'd1);
        pop_check(0, "t1_data");
        check("t1_ovr", {31'd0, ovr_a}, 32'd0);
        read_pulse(0);
        check("t1_read_clr", {31'd0, ready_a}, 32'd0);

        // overlapping header prefix
        send(0, 32'h2A5, 10);
        q_a.push_back(32'hF0);
        send(0, 32'hF0, 8);
        check("t2_ready", {31'd0, ready_a}, 32'd1);
        pop_check(0, "t2_data");
        check("t2_ovr", {31'd0, ovr_a}, 32'd0);
        read_pulse(0);

        // header value as payload must not start a new frame
        send(0, 32'hA5, 8);
        q_a.push_back(32'hA5);
        send(0, 32'hA5, 8);
        pop_check(0, "t3_data");
        read_pulse(0);
        rnd = 8'($urandom_range(0, 255));
        if (rnd == 8'hA5) rnd = 8'h5A;
        send(0, {24'd0, rnd}, 8);
        check("t3_nofalse", {31'd0, ready_a}, 32'd0);
        check("t3_ovr", {31'd0, ovr_a}, 32'd0);

        // overrun, newest wins
        send(0, 32'hA5, 8);
        q_a.push_back(32'h11);
        send(0, 32'h11, 8);
        pop_check(0, "t4_data1");
        send(0, 32'hA5, 8);
        q_a.push_back(32'h22);
        send(0, 32'h22, 8);
        pop_check(0, "t4_data2");
        check("t4_ready", {31'd0, ready_a}, 32'd1);
        check("t4_ovr", {31'd0, ovr_a}, 32'd1);
        read_pulse(0);
        check("t4_rd_ready", {31'd0, ready_a}, 32'd0);
        check("t4_rd_ovr", {31'd0, ovr_a}, 32'd0);

        // read coincides with completion
        send(0, 32'hA5, 8);
        send(0, 32'h33, 8);
        send(0, 32'hA5, 8);
        q_a.push_back(32'h44);
        send(0, 32'h22, 7);
        rd_a = 1'b1;
        send(0, 32'h0, 1);
        rd_a = 1'b0;
        check("t5_ready", {31'd0, ready_a}, 32'd1);
        check("t5_ovr", {31'd0, ovr_a}, 32'd0);
        pop_check(0, "t5_data");
        read_pulse(0);

        // parity instance: good frame
        send(1, 32'hB, 4);
        send(1, 32'hABC, 12);
        check("p1_ready_early", {31'd0, ready_b}, 32'd0);
        q_b.push_back(32'hABC);
        send(1, 32'h0, 1);
        check("p1_ready", {31'd0, ready_b}, 32'd1);
        check("p1_perr", {31'd0, perr_b}, 32'd0);
        pop_check(1, "p1_data");

        // bad parity with a different payload while ready is held
        send(1, 32'hB, 4);
        send(1, 32'h123, 12);
        send(1, 32'h0, 1);
        check("p2_perr", {31'd0, perr_b}, 32'd1);
        check("p2_ready", {31'd0, ready_b}, 32'd1);
        check("p2_data", {20'd0, data_b}, 32'hABC);
        check("p2_ovr", {31'd0, ovr_b}, 32'd0);
        read_pulse(1);
        check("p2_rd_perr", {31'd0, perr_b}, 32'd0);
        check("p2_rd_ready", {31'd0, ready_b}, 32'd0);

        // same payload, wrong parity bit
        send(1, 32'hB, 4);
        send(1, 32'hABC, 12);
        send(1, 32'h1, 1);
        check("p3_perr", {31'd0, perr_b}, 32'd1);
        check("p3_ready", {31'd0, ready_b}, 32'd0);
        check("p3_data", {20'd0, data_b}, 32'hABC);

        // reset mid-body with a pending frame
        send(0, 32'hA5, 8);
        q_a.push_back(32'h77);
        send(0, 32'h77, 8);
        pop_check(0, "r_pre_data");
        send(0, 32'hA5, 8);
        send(0, 32'h5, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_ready_a", {31'd0, ready_a}, 32'd0);
        check("r_data_a", {24'd0, data_a}, 32'd0);
        check("r_perr_b", {31'd0, perr_b}, 32'd0);
        check("r_data_b", {20'd0, data_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        send(0, 32'hA5, 8);
        q_a.push_back(32'h5A);
        send(0, 32'h5A, 8);
        check("r_post_ready", {31'd0, ready_a}, 32'd1);
        pop_check(0, "r_post_data");
        check("r_post_ovr", {31'd0, ovr_a}, 32'd0);
        send(1, 32'hB, 4);
        send(1, 32'h5A5, 12);
        q_b.push_back(32'h5A5);
        send(1, 32'h1, 1);
        check("r_post_ready_b", {31'd0, ready_b}, 32'd1);
        pop_check(1, "r_post_data_b");

        check("sb_empty", q_a.size() + q_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rcvr_param.md
Name: rcvr_param

Overview:
- Parametrised serial frame receiver; next generation of the team's fixed 8-bit, 0xA5-header receiver.
- Hunts a 1-bit serial stream for a programmable header, then shifts in a BODY_WIDTH payload MSB first.
- Optionally checks a trailing parity bit, then presents the payload on a parallel register with ready/overrun status for a polling consumer.
- Sits between a serial pin synchroniser and a register-mapped host interface.

Parameters:
HEAD_WIDTH, 8, header length in bits (2..16)
HEAD_PATTERN, 8'hA5, header value, MSB received first; width HEAD_WIDTH
BODY_WIDTH, 8, payload length in bits (1..32)
PARITY_EN, 0, 1 = one parity bit follows the payload; 0 = no parity bit
PARITY_ODD, 1, 1 = odd parity over payload+parity bit; 0 = even (ignored when PARITY_EN=0)

Ports:
clock  input  1  single clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
data_in  input  1  serial data, sampled every rising clock edge, already synchronised
reading  input  1  host read strobe; one-cycle pulse acknowledges data_out/status
ready  output  1  data_out holds an unread frame
overrun  output  1  a frame completed while ready was still set
parity_err  output  1  a frame was discarded for bad parity (tied 0 when PARITY_EN=0)
data_out  output  BODY_WIDTH  last good payload, first-received bit at MSB

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=HUNT, header window and fill count cleared, bit counter=0.
  - ready=0, overrun=0, parity_err=0, data_out=0.
  - Reset asserted mid-frame abandons the frame; no status change besides clearing.
- Reset release: synchronous in effect; the first sampling edge is the first edge with reset_n high.
- States: HUNT, BODY, PAR (PAR exists only when PARITY_EN=1).
- HUNT:
  - Each edge shifts data_in into a HEAD_WIDTH window (new bit at LSB) and increments a saturating fill count.
  - Match = (fill count reaches HEAD_WIDTH including this bit) AND ({window,data_in} low HEAD_WIDTH bits == HEAD_PATTERN).
  - Sliding compare handles overlapping prefixes. Example for 0xA5: stream 1,0,1,0,1,0,0,1,0,1 matches on the final bit.
  - On match: state to BODY, bit counter=0.
  - The window and fill count are cleared on every entry to HUNT. Payload or parity bits never contribute to a header match.
- BODY:
  - Each edge shifts data_in into the body shift register and increments the bit counter.
  - On the edge sampling bit BODY_WIDTH-1 (last): go to PAR if PARITY_EN, else complete the frame and go to HUNT.
- PAR:
  - One edge samples the parity bit.
  - Parity good: complete the frame. Parity bad: discard the frame. Either way go to HUNT.
- Frame completion (on the same edge as the last sampled bit):
  - data_out <= {body_shift, data_in}, or the stored payload when in PAR.
  - ready <= 1.
  - Latency: ready and data_out are visible the cycle after the last frame bit is sampled.
- Discard (bad parity): data_out and ready unchanged; parity_err <= 1.
- Status update priority, each edge:
  - ready: completion sets it; else reading clears it. Completion together with reading leaves ready=1.
  - overrun: reading clears it; else completion while ready=1 sets it. The new frame overwrites data_out (newest wins).
  - parity_err: reading clears it; else discard sets it.
- reading while ready=0: harmless; clears overrun and parity_err only.
- Back-to-back frames: HUNT restarts on the edge after the last frame bit. The next header may start immediately, with no idle bit required.
- Counter widths: bit counter is clog2(BODY_WIDTH+1) bits. Fill count saturates at HEAD_WIDTH.
- Illegal or unreachable state encoding returns to HUNT on the next edge.

Test Plan:
- Defaults, send 10100101 then 00111100, no reading -> ready=1 and data_out=8'h3C one cycle after the last bit; overrun=0.
- Overlapping header: send 1010100101 then 11110000 -> one match, data_out=8'hF0. Send 0xA5 as a payload followed by 8 random bits -> no false frame.
- Overrun: two frames, payloads 8'h11 then 8'h22, no reading -> data_out=8'h22, ready=1, overrun=1. Pulse reading -> ready=0, overrun=0 next cycle.
- Simultaneous events: reading pulsed on the edge sampling the last bit of frame 2 while ready=1 -> ready=1, overrun=0, data_out=frame 2 payload.
- PARITY_EN=1, PARITY_ODD=1, BODY_WIDTH=12, HEAD=4'hB:
  - Payload 12'hABC with parity bit 0 (7 ones + 0 = odd) -> ready=1, data_out=12'hABC.
  - Same payload with parity bit 1 -> parity_err=1, ready and data_out unchanged.
- Reset mid-body: assert reset_n low after 4 payload bits -> all outputs 0 immediately. A full valid frame after release -> correct data_out, ready=1.
